// File: rtl/immgen_stage_pkg.sv
// Shared constants for the immediate-generator stage: selector width and codes.
package immgen_stage_pkg;
    localparam int IMMSEL_W = 4;

    localparam logic [IMMSEL_W-1:0] IMM_I    = 4'd0;
    localparam logic [IMMSEL_W-1:0] IMM_S    = 4'd1;
    localparam logic [IMMSEL_W-1:0] IMM_B    = 4'd2;
    localparam logic [IMMSEL_W-1:0] IMM_U    = 4'd3;
    localparam logic [IMMSEL_W-1:0] IMM_J    = 4'd4;
    localparam logic [IMMSEL_W-1:0] IMM_Z    = 4'd5;
    localparam logic [IMMSEL_W-1:0] IMM_SH   = 4'd6;
    localparam logic [IMMSEL_W-1:0] IMM_NONE = 4'd7;
    localparam logic [IMMSEL_W-1:0] IMM_CI   = 4'd8;
    localparam logic [IMMSEL_W-1:0] IMM_CJ   = 4'd9;
    localparam logic [IMMSEL_W-1:0] IMM_CB   = 4'd10;
    localparam logic [IMMSEL_W-1:0] IMM_CIW  = 4'd11;
endpackage

// File: rtl/immgen_stage_imm_extract.sv
// Combinational immediate extraction for base and compressed formats.
module imm_extract
    import immgen_stage_pkg::*;
#(
    parameter int XLEN = 64,
    parameter bit RVC  = 1'b1
) (
    input  logic [31:0]         inst,
    input  logic [IMMSEL_W-1:0] immsel,
    output logic [XLEN-1:0]     imm,
    output logic                err
);
    // The opcode size bits never contribute to any immediate.
    logic unused_opcode_bits;
    assign unused_opcode_bits = ^inst[1:0];

    always_comb begin
        imm = '0;
        err = 1'b0;
        case (immsel)
            IMM_I:    imm = XLEN'($signed(inst[31:20]));
            IMM_S:    imm = XLEN'($signed({inst[31:25], inst[11:7]}));
            IMM_B:    imm = XLEN'($signed({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}));
            IMM_U:    imm = XLEN'($signed({inst[31:12], 12'b0}));
            IMM_J:    imm = XLEN'($signed({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}));
            IMM_Z:    imm = XLEN'(inst[19:15]);
            IMM_SH:   imm = (XLEN == 64) ? XLEN'(inst[25:20]) : XLEN'(inst[24:20]);
            IMM_NONE: imm = '0;
            IMM_CI:   if (RVC) imm = XLEN'($signed({inst[12], inst[6:2]}));
                      else     err = 1'b1;
            IMM_CJ:   if (RVC) imm = XLEN'($signed({inst[12], inst[8], inst[10:9], inst[6],
                                                    inst[7], inst[2], inst[11], inst[5:3], 1'b0}));
                      else     err = 1'b1;
            IMM_CB:   if (RVC) imm = XLEN'($signed({inst[12], inst[6:5], inst[2], inst[11:10],
                                                    inst[4:3], 1'b0}));
                      else     err = 1'b1;
            IMM_CIW:  if (RVC) imm = XLEN'({inst[10:7], inst[12:11], inst[5], inst[6], 2'b00});
                      else     err = 1'b1;
            default:  err = 1'b1;
        endcase
    end
endmodule

// File: rtl/immgen_stage.sv
// Registered immediate generator with a 2-entry skid buffer and saturating error counter.
module immgen_stage
    import immgen_stage_pkg::*;
#(
    parameter int XLEN   = 64,
    parameter bit RVC    = 1'b1,
    parameter int ECNT_W = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                flush,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [31:0]         in_inst,
    input  logic [IMMSEL_W-1:0] in_immsel,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [31:0]         out_inst,
    output logic [XLEN-1:0]     out_imm,
    output logic                out_err,
    output logic [ECNT_W-1:0]   err_cnt
);
    localparam logic [ECNT_W-1:0] CNT_MAX = '1;

    logic [XLEN-1:0]   ext_imm;
    logic              ext_err;

    logic              main_valid_reg;
    logic [31:0]       main_inst_reg;
    logic [XLEN-1:0]   main_imm_reg;
    logic              main_err_reg;
    logic              skid_valid_reg;
    logic [31:0]       skid_inst_reg;
    logic [XLEN-1:0]   skid_imm_reg;
    logic              skid_err_reg;
    logic [ECNT_W-1:0] err_cnt_reg;

    logic in_fire;
    logic out_fire;
    logic main_open;

    imm_extract #(.XLEN(XLEN), .RVC(RVC)) u_extract (
        .inst   (in_inst),
        .immsel (in_immsel),
        .imm    (ext_imm),
        .err    (ext_err)
    );

    // in_ready comes straight from a flop: the skid entry is the only thing that can block input.
    assign in_ready  = !skid_valid_reg;
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = main_valid_reg && out_ready;
    assign main_open = !main_valid_reg || out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_valid_reg <= 1'b0;
            main_inst_reg  <= '0;
            main_imm_reg   <= '0;
            main_err_reg   <= 1'b0;
            skid_valid_reg <= 1'b0;
            skid_inst_reg  <= '0;
            skid_imm_reg   <= '0;
            skid_err_reg   <= 1'b0;
        end else if (flush) begin
            main_valid_reg <= 1'b0;
            skid_valid_reg <= 1'b0;
        end else if (main_open) begin
            if (skid_valid_reg) begin
                // Skid full means in_ready was low, so no new entry competes this cycle.
                main_valid_reg <= 1'b1;
                main_inst_reg  <= skid_inst_reg;
                main_imm_reg   <= skid_imm_reg;
                main_err_reg   <= skid_err_reg;
                skid_valid_reg <= 1'b0;
            end else if (in_fire) begin
                main_valid_reg <= 1'b1;
                main_inst_reg  <= in_inst;
                main_imm_reg   <= ext_imm;
                main_err_reg   <= ext_err;
            end else begin
                main_valid_reg <= 1'b0;
            end
        end else if (in_fire) begin
            skid_valid_reg <= 1'b1;
            skid_inst_reg  <= in_inst;
            skid_imm_reg   <= ext_imm;
            skid_err_reg   <= ext_err;
        end
    end

    // Counts every erroneous handshake the consumer sees, flush or not.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt_reg <= '0;
        end else if (out_fire && main_err_reg && (err_cnt_reg != CNT_MAX)) begin
            err_cnt_reg <= err_cnt_reg + 1'b1;
        end
    end

    assign out_valid = main_valid_reg;
    assign out_inst  = main_inst_reg;
    assign out_imm   = main_imm_reg;
    assign out_err   = main_err_reg;
    assign err_cnt   = err_cnt_reg;
endmodule

// File: tb/tb_immgen_stage.sv
// Bench for immgen_stage: a 64-bit RVC build and a 32-bit non-RVC build with a 2-bit counter.
module tb_immgen_stage;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_inst = '0;
    logic [3:0]  in_immsel = '0;
    logic        out_ready = 1'b0;

    logic        a_in_ready, a_out_valid, a_out_err;
    logic [31:0] a_out_inst;
    logic [63:0] a_out_imm;
    logic [7:0]  a_err_cnt;
    logic        b_in_ready, b_out_valid, b_out_err;
    logic [31:0] b_out_inst;
    logic [31:0] b_out_imm;
    logic [1:0]  b_err_cnt;

    int n_cmp = 0;
    int n_fail = 0;
    int exp_cnt_a = 0;
    int exp_cnt_b = 0;

    always #5 clk = ~clk;

    immgen_stage #(.XLEN(64), .RVC(1'b1), .ECNT_W(8)) dut_a (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(a_in_ready),
        .in_inst(in_inst), .in_immsel(in_immsel), .out_valid(a_out_valid), .out_ready(out_ready),
        .out_inst(a_out_inst), .out_imm(a_out_imm), .out_err(a_out_err), .err_cnt(a_err_cnt));

    immgen_stage #(.XLEN(32), .RVC(1'b0), .ECNT_W(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(b_in_ready),
        .in_inst(in_inst), .in_immsel(in_immsel), .out_valid(b_out_valid), .out_ready(out_ready),
        .out_inst(b_out_inst), .out_imm(b_out_imm), .out_err(b_out_err), .err_cnt(b_err_cnt));

    function automatic longint fld(input logic [31:0] w, input int hi, input int lo);
        return (longint'(w) >> lo) & ((longint'(1) << (hi - lo + 1)) - 1);
    endfunction

    function automatic longint sx(input longint raw, input int bits);
        return (raw >= (longint'(1) << (bits - 1))) ? raw - (longint'(1) << bits) : raw;
    endfunction

    // Reference: the immediate as a mathematical integer, then truncated to XLEN.
    function automatic void ref_model(input logic [31:0] w, input int sel, input int xlen,
                                      input bit rvc, output logic [63:0] imm, output bit err);
        longint v;
        v = 0;
        err = 1'b0;
        case (sel)
            0: v = sx(fld(w, 31, 20), 12);
            1: v = sx(fld(w, 31, 25) * 32 + fld(w, 11, 7), 12);
            2: v = sx(fld(w, 31, 31) * 4096 + fld(w, 7, 7) * 2048 + fld(w, 30, 25) * 32
                      + fld(w, 11, 8) * 2, 13);
            3: v = sx(fld(w, 31, 12) * 4096, 32);
            4: v = sx(fld(w, 31, 31) * 1048576 + fld(w, 19, 12) * 4096 + fld(w, 20, 20) * 2048
                      + fld(w, 30, 21) * 2, 21);
            5: v = fld(w, 19, 15);
            6: v = (xlen == 64) ? fld(w, 25, 20) : fld(w, 24, 20);
            7: v = 0;
            8: v = sx(fld(w, 12, 12) * 32 + fld(w, 6, 2), 6);
            9: v = sx(fld(w, 12, 12) * 2048 + fld(w, 8, 8) * 1024 + fld(w, 10, 9) * 256
                      + fld(w, 6, 6) * 128 + fld(w, 7, 7) * 64 + fld(w, 2, 2) * 32
                      + fld(w, 11, 11) * 16 + fld(w, 5, 3) * 2, 12);
            10: v = sx(fld(w, 12, 12) * 256 + fld(w, 6, 5) * 64 + fld(w, 2, 2) * 32
                       + fld(w, 11, 10) * 8 + fld(w, 4, 3) * 2, 9);
            11: v = fld(w, 10, 7) * 64 + fld(w, 12, 11) * 16 + fld(w, 5, 5) * 8 + fld(w, 6, 6) * 4;
            default: err = 1'b1;
        endcase
        if (sel >= 8 && sel <= 11 && !rvc) err = 1'b1;
        if (err) v = 0;
        imm = (xlen == 32) ? (64'(v) & 64'hFFFF_FFFF) : 64'(v);
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        #12 rst_n = 1'b1;
        #1;
        n_cmp++; if (a_out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", a_out_valid); end
        n_cmp++; if (a_in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", a_in_ready); end
        n_cmp++; if (a_err_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_err_cnt got %0d want 0", a_err_cnt); end
        n_cmp++; if (a_out_inst !== 32'd0 || a_out_imm !== 64'd0 || a_out_err !== 1'b0) begin
            n_fail++; $display("FAIL reset_out_data got inst=%h imm=%h err=%b want zeros", a_out_inst, a_out_imm, a_out_err); end
        n_cmp++; if (b_out_valid !== 1'b0 || b_in_ready !== 1'b1 || b_err_cnt !== 2'd0) begin
            n_fail++; $display("FAIL reset_b got valid=%b ready=%b cnt=%0d want 0/1/0", b_out_valid, b_in_ready, b_err_cnt); end
        $display("reset: done");
    endtask

    // Directed vectors first, then random back-to-back traffic at full throughput.
    task automatic test_formats();
        logic [31:0] dir_inst [4] = '{32'hFFF0_0093, 32'h0040_006F, 32'h000F_8073, 32'h0000_BFFD};
        int          dir_sel  [4] = '{0, 4, 5, 9};
        logic [63:0] ea, eb;
        bit          erra, errb;
        out_ready = 1'b1;
        for (int i = 0; i < 44; i++) begin
            if (i < 4) begin
                in_inst = dir_inst[i];
                in_immsel = 4'(dir_sel[i]);
            end else begin
                in_inst = $urandom;
                in_immsel = 4'($urandom_range(0, 15));
            end
            in_valid = 1'b1;
            ref_model(in_inst, int'(in_immsel), 64, 1'b1, ea, erra);
            ref_model(in_inst, int'(in_immsel), 32, 1'b0, eb, errb);
            @(posedge clk); #1;
            $display("xfer %0d: inst=%h sel=%0d a_imm=%h a_err=%b b_imm=%h b_err=%b",
                     i, in_inst, in_immsel, a_out_imm, a_out_err, b_out_imm, b_out_err);
            n_cmp++; if (a_out_valid !== 1'b1 || a_out_inst !== in_inst) begin
                n_fail++; $display("FAIL fmt_a_valid_inst[%0d] got %b/%h want 1/%h", i, a_out_valid, a_out_inst, in_inst); end
            n_cmp++; if (a_out_imm !== ea || a_out_err !== erra) begin
                n_fail++; $display("FAIL fmt_a_imm[%0d] sel=%0d got %h/%b want %h/%b", i, in_immsel, a_out_imm, a_out_err, ea, erra); end
            n_cmp++; if (b_out_valid !== 1'b1 || b_out_imm !== eb[31:0] || b_out_err !== errb) begin
                n_fail++; $display("FAIL fmt_b_imm[%0d] sel=%0d got %b/%h/%b want 1/%h/%b", i, in_immsel, b_out_valid, b_out_imm, b_out_err, eb[31:0], errb); end
            n_cmp++; if (a_err_cnt !== 8'(exp_cnt_a) || b_err_cnt !== 2'(exp_cnt_b)) begin
                n_fail++; $display("FAIL fmt_err_cnt[%0d] got %0d/%0d want %0d/%0d", i, a_err_cnt, b_err_cnt, exp_cnt_a, exp_cnt_b); end
            if (erra && exp_cnt_a < 255) exp_cnt_a++;
            if (errb && exp_cnt_b < 3) exp_cnt_b++;
        end
        in_valid = 1'b0;
        @(posedge clk); #1;
        n_cmp++; if (a_out_valid !== 1'b0 || a_err_cnt !== 8'(exp_cnt_a) || b_err_cnt !== 2'(exp_cnt_b)) begin
            n_fail++; $display("FAIL fmt_drain got %b %0d/%0d want 0 %0d/%0d", a_out_valid, a_err_cnt, b_err_cnt, exp_cnt_a, exp_cnt_b); end
    endtask

    task automatic test_backpressure();
        logic [31:0] w [3];
        logic [3:0]  s [3];
        logic [63:0] e;
        bit          er;
        for (int i = 0; i < 3; i++) begin
            w[i] = $urandom;
            s[i] = 4'($urandom_range(0, 7));
        end
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_inst = w[i]; in_immsel = s[i];
            @(posedge clk); #1;
            $display("bp offer %0d: inst=%h out_inst=%h in_ready=%b", i, w[i], a_out_inst, a_in_ready);
            n_cmp++; if (a_out_valid !== 1'b1 || a_out_inst !== w[0]) begin
                n_fail++; $display("FAIL bp_hold[%0d] got %b/%h want 1/%h", i, a_out_valid, a_out_inst, w[0]); end
            n_cmp++; if (a_in_ready !== (i == 0) || b_in_ready !== (i == 0)) begin
                n_fail++; $display("FAIL bp_in_ready[%0d] got %b/%b want %b", i, a_in_ready, b_in_ready, i == 0); end
        end
        // C is still offered; release the consumer and expect A (already seen), B, C with no gaps.
        out_ready = 1'b1;
        for (int i = 1; i < 3; i++) begin
            @(posedge clk); #1;
            if (i == 2) in_valid = 1'b0;
            ref_model(w[i], int'(s[i]), 64, 1'b1, e, er);
            $display("bp drain %0d: out_inst=%h out_imm=%h", i, a_out_inst, a_out_imm);
            n_cmp++; if (a_out_valid !== 1'b1 || a_out_inst !== w[i] || a_out_imm !== e) begin
                n_fail++; $display("FAIL bp_order[%0d] got %b/%h/%h want 1/%h/%h", i, a_out_valid, a_out_inst, a_out_imm, w[i], e); end
            n_cmp++; if (a_in_ready !== 1'b1) begin
                n_fail++; $display("FAIL bp_ready_rise[%0d] got %b want 1", i, a_in_ready); end
        end
        @(posedge clk); #1;
        n_cmp++; if (a_out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_empty got %b want 0", a_out_valid); end
    endtask

    task automatic test_flush();
        logic [31:0] d;
        out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1; in_inst = $urandom; in_immsel = 4'd7;
            @(posedge clk); #1;
        end
        n_cmp++; if (a_in_ready !== 1'b0) begin n_fail++; $display("FAIL flush_prefill got %b want 0", a_in_ready); end
        flush = 1'b1; in_inst = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        flush = 1'b0;
        $display("flush: out_valid=%b in_ready=%b", a_out_valid, a_in_ready);
        n_cmp++; if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1 || b_out_valid !== 1'b0) begin
            n_fail++; $display("FAIL flush_clear got %b/%b/%b want 0/1/0", a_out_valid, a_in_ready, b_out_valid); end
        d = $urandom; in_inst = d; in_immsel = 4'd0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        $display("flush next: out_inst=%h", a_out_inst);
        n_cmp++; if (a_out_valid !== 1'b1 || a_out_inst !== d) begin
            n_fail++; $display("FAIL flush_next got %b/%h want 1/%h", a_out_valid, a_out_inst, d); end
        out_ready = 1'b1;
        @(posedge clk); #1;
        n_cmp++; if (a_out_valid !== 1'b0 || a_err_cnt !== 8'(exp_cnt_a)) begin
            n_fail++; $display("FAIL flush_cnt got %b/%0d want 0/%0d", a_out_valid, a_err_cnt, exp_cnt_a); end
    endtask

    task automatic test_async_reset();
        out_ready = 1'b0;
        in_valid = 1'b1; in_inst = $urandom; in_immsel = 4'd13;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n_cmp++; if (a_out_valid !== 1'b1) begin n_fail++; $display("FAIL areset_pre got %b want 1", a_out_valid); end
        #1 rst_n = 1'b0;
        #1;
        $display("async reset: out_valid=%b err_cnt=%0d", a_out_valid, a_err_cnt);
        n_cmp++; if (a_out_valid !== 1'b0 || a_err_cnt !== 8'd0 || b_err_cnt !== 2'd0 || a_in_ready !== 1'b1) begin
            n_fail++; $display("FAIL areset got valid=%b cnt=%0d/%0d ready=%b want 0 0/0 1", a_out_valid, a_err_cnt, b_err_cnt, a_in_ready); end
        #1 rst_n = 1'b1;
        exp_cnt_a = 0; exp_cnt_b = 0;
    endtask

    task automatic test_err_saturation();
        @(posedge clk); #1;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; in_inst = $urandom; in_immsel = 4'd12;
            @(posedge clk); #1;
            n_cmp++; if (a_out_err !== 1'b1 || a_out_imm !== 64'd0 || a_out_inst !== in_inst) begin
                n_fail++; $display("FAIL sat_err[%0d] got %b/%h/%h want 1/0/%h", i, a_out_err, a_out_imm, a_out_inst, in_inst); end
        end
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        $display("saturation: a_err_cnt=%0d b_err_cnt=%0d", a_err_cnt, b_err_cnt);
        n_cmp++; if (a_err_cnt !== 8'd5) begin n_fail++; $display("FAIL sat_cnt_a got %0d want 5", a_err_cnt); end
        n_cmp++; if (b_err_cnt !== 2'd3) begin n_fail++; $display("FAIL sat_cnt_b got %0d want 3", b_err_cnt); end
    endtask

    initial begin
        test_reset();
        test_formats();
        test_backpressure();
        test_flush();
        test_async_reset();
        test_err_saturation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
